dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the pipeline execute stage (P port) and a debug/loader port (D port) used by benches and program loaders.
- P port has priority. D port has a bounded-wait starvation guard and an optional lock mode for burst transfers.
- Sits between the execute stage and the `memory` instance.
- Drives a stall request that the hazard unit ORs into stall_F/stall_D.

---
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (pipeline P, debug D)
// and the single-port data memory.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
);
    logic              p_req;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_gnt;
    logic              p_stall;
    logic              p_rvalid;
    logic [DATA_W-1:0] p_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              locked;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_gnt, p_stall, p_rvalid, p_rdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output locked
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_gnt, p_stall, p_rvalid, p_rdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  locked
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: P has priority, D has a bounded-wait guard and a lock mode for bursts.
// Optional performance counters are enabled with the DMEM_ARB_PERF_EN macro.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_arbiter_if.slave      bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        d_win_cnt
`endif
);

    localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

    typedef enum logic [0:0] {StArb, StLock} state_e;

    state_e            state_q;
    logic [WaitW-1:0]  wait_q;
    logic              locked_q;
    logic              p_rvalid_q;
    logic              d_rvalid_q;

    logic              p_gnt;
    logic              d_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grants are purely combinational so a granted access reaches memory in the same cycle.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        unique case (state_q)
            StArb: begin
                if (bus.d_req && (!bus.p_req || wait_q >= MaxWait)) begin
                    d_gnt = 1'b1;
                end else if (bus.p_req) begin
                    p_gnt = 1'b1;
                end
            end
            StLock: d_gnt = bus.d_req;
            default: ;
        endcase
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = bus.p_addr;
        sel_wdata = bus.p_wdata;
        if (d_gnt) begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end else if (p_gnt) begin
            sel_we    = bus.p_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StArb;
            wait_q     <= '0;
            locked_q   <= 1'b0;
            p_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            p_rvalid_q <= p_gnt & ~bus.p_we;
            d_rvalid_q <= d_gnt & ~bus.d_we;
            unique case (state_q)
                StArb: begin
                    // Count only conflicts that D lost; any other outcome restarts the guard.
                    if (!bus.d_req || d_gnt) begin
                        wait_q <= '0;
                    end else if (wait_q != MaxWait) begin
                        wait_q <= wait_q + 1'b1;
                    end
                    if (d_gnt && bus.d_lock) begin
                        state_q  <= StLock;
                        locked_q <= 1'b1;
                    end
                end
                StLock: begin
                    wait_q <= '0;
                    if (!bus.d_req || !bus.d_lock) begin
                        state_q  <= StArb;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StArb;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            d_win_cnt <= '0;
        end else begin
            if (bus.p_req && !p_gnt && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (d_gnt && bus.p_req && d_win_cnt != 16'hFFFF) begin
                d_win_cnt <= d_win_cnt + 16'd1;
            end
        end
    end
`endif

    assign bus.p_gnt     = p_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.p_stall   = bus.p_req & ~p_gnt;
    assign bus.p_rvalid  = p_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.p_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic against a
// cycle-level reference model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] d_win_cnt;
`endif

    dmem_arbiter #(.ADDR_W(11), .DATA_W(16), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .d_win_cnt (d_win_cnt)
`endif
    );

    // Synchronous-read data memory the arbiter drives.
    logic [15:0] mem [2048];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference model state.
    logic [15:0] ref_mem [2048];
    int          lost;
    bit          m_locked;
    bit          pend_p, pend_d;
    logic [15:0] pend_p_data, pend_d_data;
    int          exp_stall_cnt, exp_dwin;

    int n_pass = 0, n_fail = 0, n_total = 0;

    logic        last_p_gnt, last_d_gnt, last_p_stall, last_locked;
    logic        last_p_rvalid, last_d_rvalid;
    logic [15:0] last_p_rdata;
    logic [15:0] last_stall_cnt, last_dwin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit pr, input bit pw, input logic [10:0] pa,
                        input logic [15:0] pwd, input bit dr, input bit dw, input bit dl,
                        input logic [10:0] da, input logic [15:0] dwd);
        bit          eg_p, eg_d, e_stall, e_we;
        logic [10:0] e_addr;
        logic [15:0] e_wd;
        rst = r;
        bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pwd;
        bus.d_req = dr; bus.d_we = dw; bus.d_lock = dl; bus.d_addr = da; bus.d_wdata = dwd;
        if (m_locked) begin
            eg_d = dr; eg_p = 1'b0;
        end else if (dr && (!pr || lost >= MAX_WAIT)) begin
            eg_d = 1'b1; eg_p = 1'b0;
        end else begin
            eg_d = 1'b0; eg_p = pr;
        end
        e_stall = pr && !eg_p;
        e_we    = eg_d ? dw : (eg_p && pw);
        e_addr  = eg_d ? da : pa;
        e_wd    = eg_d ? dwd : pwd;
        @(negedge clk);
        chk("p_gnt", 32'(bus.p_gnt), 32'(eg_p));
        chk("d_gnt", 32'(bus.d_gnt), 32'(eg_d));
        chk("p_stall", 32'(bus.p_stall), 32'(e_stall));
        chk("locked", 32'(bus.locked), 32'(m_locked));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
        chk("p_rvalid", 32'(bus.p_rvalid), 32'(pend_p));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(pend_d));
        if (pend_p) chk("p_rdata", 32'(bus.p_rdata), 32'(pend_p_data));
        if (pend_d) chk("d_rdata", 32'(bus.d_rdata), 32'(pend_d_data));
`ifdef DMEM_ARB_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall_cnt));
        chk("d_win_cnt", 32'(d_win_cnt), 32'(exp_dwin));
        last_stall_cnt = stall_cnt;
        last_dwin      = d_win_cnt;
`endif
        last_p_gnt = bus.p_gnt; last_d_gnt = bus.d_gnt; last_p_stall = bus.p_stall;
        last_locked = bus.locked; last_p_rvalid = bus.p_rvalid; last_d_rvalid = bus.d_rvalid;
        last_p_rdata = bus.p_rdata;
        @(posedge clk);
        if (!r) begin
            lost = 0; m_locked = 1'b0; pend_p = 1'b0; pend_d = 1'b0;
            exp_stall_cnt = 0; exp_dwin = 0;
        end else begin
            pend_p = eg_p && !pw; pend_p_data = ref_mem[pa];
            pend_d = eg_d && !dw; pend_d_data = ref_mem[da];
            if (e_stall && exp_stall_cnt < 65535) exp_stall_cnt++;
            if (eg_d && pr && exp_dwin < 65535) exp_dwin++;
            lost = (m_locked || !dr || eg_d) ? 0 : ((lost < MAX_WAIT) ? lost + 1 : lost);
            m_locked = m_locked ? (dr && dl) : (eg_d && dl);
        end
        if (e_we) ref_mem[e_addr] = e_wd;
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 16'(i * 40503) ^ 16'h5A5A;
            ref_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        end
        mem[16'h010]     = 16'hBEEF;
        ref_mem[16'h010] = 16'hBEEF;
        lost = 0; m_locked = 1'b0; pend_p = 1'b0; pend_d = 1'b0;
        pend_p_data = '0; pend_d_data = '0; exp_stall_cnt = 0; exp_dwin = 0;
        rst = 1'b0;
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        @(posedge clk); #1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 11'h0, 16'h0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        chk("rst_p_rvalid", 32'(last_p_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(last_d_rvalid), 32'd0);
        chk("rst_locked", 32'(last_locked), 32'd0);

        // P-only read of preloaded word
        step(1'b1, 1'b1, 1'b0, 11'h010, 16'h0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        chk("pread_gnt", 32'(last_p_gnt), 32'd1);
        idle();
        chk("pread_rvalid", 32'(last_p_rvalid), 32'd1);
        chk("pread_rdata", 32'(last_p_rdata), 32'hBEEF);
        chk("pread_d_rvalid", 32'(last_d_rvalid), 32'd0);

        // D write followed by P read of the same word
        step(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 1'b1, 1'b1, 1'b0, 11'h002, 16'h1234);
        chk("dwr_gnt", 32'(last_d_gnt), 32'd1);
        step(1'b1, 1'b1, 1'b0, 11'h002, 16'h0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        chk("prd_gnt", 32'(last_p_gnt), 32'd1);
        chk("prd_nostall", 32'(last_p_stall), 32'd0);
        idle();
        chk("prd_rdata", 32'(last_p_rdata), 32'h1234);

        // Sustained conflict: D wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 11'h003, 16'h0, 1'b1, 1'b0, 1'b0, 11'h004, 16'h0);
            chk("conf_d_gnt", 32'(last_d_gnt), 32'((i % 5) == 4));
            chk("conf_stall", 32'(last_p_stall), 32'((i % 5) == 4));
        end
        idle();
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall_cnt", 32'(last_stall_cnt), 32'd2);
        chk("perf_d_win_cnt", 32'(last_dwin), 32'd2);
`endif

        // Locked D burst blocks P; release lets P in the next cycle
        step(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 1'b1, 1'b0, 1'b1, 11'h005, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 11'h006, 16'h0, 1'b1, 1'b0, 1'b1, 11'(6 + i), 16'h0);
            chk("lock_locked", 32'(last_locked), 32'd1);
            chk("lock_stall", 32'(last_p_stall), 32'd1);
        end
        step(1'b1, 1'b1, 1'b0, 11'h006, 16'h0, 1'b1, 1'b0, 1'b0, 11'h009, 16'h0);
        chk("release_d_gnt", 32'(last_d_gnt), 32'd1);
        step(1'b1, 1'b1, 1'b0, 11'h006, 16'h0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        chk("release_p_gnt", 32'(last_p_gnt), 32'd1);
        chk("release_unlocked", 32'(last_locked), 32'd0);

        // Reset while locked with a D read issuing
        step(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 1'b1, 1'b0, 1'b1, 11'h00A, 16'h0);
        step(1'b0, 1'b0, 1'b0, 11'h0, 16'h0, 1'b1, 1'b0, 1'b1, 11'h00B, 16'h0);
        step(1'b1, 1'b1, 1'b0, 11'h00C, 16'h0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        chk("rstlock_locked", 32'(last_locked), 32'd0);
        chk("rstlock_d_rvalid", 32'(last_d_rvalid), 32'd0);
        chk("rstlock_p_gnt", 32'(last_p_gnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 11'h003, 16'h0, 1'b1, 1'b0, 1'b0, 11'h004, 16'h0);
            chk("rstlock_wait", 32'(last_d_gnt), 32'(i == 4));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                 11'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                 11'($urandom_range(0, 15)), 16'($urandom));
        end

`ifdef DMEM_ARB_PERF_EN
        // Saturate the stall counter with a long locked burst
        idle();
        step(1'b1, 1'b0, 1'b0, 11'h0, 16'h0, 1'b1, 1'b0, 1'b1, 11'h001, 16'h0);
        for (int i = 0; i < 70000; i++) begin
            step(1'b1, 1'b1, 1'b0, 11'h002, 16'h0, 1'b1, 1'b0, 1'b1, 11'h001, 16'h0);
        end
        idle();
        chk("perf_stall_sat", 32'(last_stall_cnt), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
